block_mean_buffer: RTL
======================

Name: block_mean_buffer

Overview:
- Receives the per-block luminance stream produced by the block-mean stage: one 8-bit mean per block, 40 blocks per block row, 20 block rows per frame.
- Stores each frame's means into a ping-pong pair of BLK_X*BLK_Y-entry buffers.
- Publishes a complete frame to the backlight/compensation side on the next vs rising edge.
- Serves random-access reads from the published bank with 1-cycle latency.

Parameters:
- BLK_X, 40, block columns per block row
- BLK_Y, 20, block rows per frame
- DW, 8, mean data width
- AW, 10, buffer address width (must satisfy 2^AW >= BLK_X*BLK_Y)

Ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- vs  in  1  video vertical sync; rising edge marks frame boundary
- block_mean  in  DW  block mean sample from upstream
- data_vaild  in  1  block_mean valid; one sample per high cycle, no backpressure
- rd_en  in  1  read request
- rd_addr  in  AW  read address = row*BLK_X + col
- rd_data  out  DW  read data, registered
- rd_valid  out  1  rd_data valid, one cycle after rd_en
- frame_done  out  1  one-cycle pulse when a bank swap occurs
- frame_valid  out  1  high once at least one complete frame has been published
- drop_err  out  1  sticky: sample arrived while buffer full, or vs arrived before frame complete

Behaviour:
- Reset: all outputs are 0. wr_col=0, wr_row=0, wr_bank=0, rd_bank=1, state=FILL. RAM contents are not cleared.
- vs_rise = vs & ~vs_d, where vs_d is registered.
- State FILL:
  - On data_vaild, write block_mean to wr_bank at address wr_row*BLK_X+wr_col.
  - wr_col increments; at BLK_X-1 it wraps to 0 and wr_row increments.
  - The write at (BLK_Y-1, BLK_X-1) moves the state to FULL.
- State FULL:
  - data_vaild writes nothing, sets drop_err, and counters hold.
- On vs_rise, regardless of state:
  - If FULL: swap banks (wr_bank<=~wr_bank, rd_bank<=~rd_bank), pulse frame_done the next cycle, set frame_valid.
  - If FILL with a partial frame (any sample written): no swap, set drop_err.
  - If FILL with zero samples written: no swap, no error.
  - In every case, clear counters and enter FILL.
- vs_rise and data_vaild in the same cycle: the boundary takes priority. The sample is written to the new wr_bank (after any swap) at address 0, and counters become col=1, row=0.
- Read: rd_en in cycle N gives rd_data/rd_valid in cycle N+1.
  - rd_data = rd_bank[rd_addr] when frame_valid=1 and rd_addr < BLK_X*BLK_Y; otherwise 0.
  - A read in the same cycle as a swap uses the pre-swap rd_bank.
  - rd_valid=0 when rd_en=0; rd_data holds its last value.
- Write and read ports are independent and never touch the same bank in the same cycle (dual-port RAM or two single-port RAMs).
- drop_err clears only on rst.
- Reset mid-frame: all state returns to reset values and frame_valid=0, so reads return 0 until the next full frame is published.
- Address arithmetic is computed at AW bits with no wrap. wr_row*BLK_X+wr_col is always < BLK_X*BLK_Y by construction.

Test Plan:
- Full frame: reset, send 800 samples with value (row*40+col)&8'hFF, then vs_rise. Expect frame_done pulse, frame_valid=1. Reading addr 0 gives 0, addr 41 gives 41, addr 799 gives 8'h1F (799&255), each with rd_valid one cycle after rd_en.
- Ping-pong: publish frame A (all 8'h10), fill frame B (all 8'h20) without vs. Reads return 8'h10. After vs_rise, reads return 8'h20.
- Overflow: 801 samples before vs. Expect drop_err=1 after the 801st sample, stored data unchanged; the next vs_rise still swaps.
- Short frame: 500 samples then vs_rise. Expect no frame_done, drop_err=1, previous frame still readable, counters restart at 0.
- Boundary collision: sample 8'hAB asserted in the same cycle as vs_rise after a full frame. Expect swap plus new-bank address 0 = 8'hAB. Reading addr 0 after the next full frame returns 8'hAB.
- Reset/range: assert rst mid-frame. Reads of addr 0 return 0 with frame_valid=0. After a valid publish, rd_addr=800 and rd_addr=1023 return 0.

Source files
------------

// File: rtl/block_mean_buffer.sv
// Ping-pong frame buffer for per-block luminance means: fills one bank from the
// block-mean stream, publishes it on the vs rising edge, and serves reads from the other.
module block_mean_buffer #(
    parameter int unsigned BLK_X = 40,
    parameter int unsigned BLK_Y = 20,
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vs,
    input  logic [DW-1:0] block_mean,
    input  logic          data_vaild,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          frame_done,
    output logic          frame_valid,
    output logic          drop_err
);

    localparam int unsigned Depth = BLK_X * BLK_Y;
    localparam int unsigned CW    = (BLK_X > 1) ? $clog2(BLK_X) : 1;
    localparam int unsigned RW    = (BLK_Y > 1) ? $clog2(BLK_Y) : 1;

    typedef enum logic [0:0] {StFill, StFull} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          vs_q;
    logic          drop_q, drop_d;
    logic          fv_q, fv_d;
    logic          done_q, done_d;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;
    logic          vs_rise;
    logic          fill;
    logic          we;
    logic [AW-1:0] waddr;

    logic [DW-1:0] mem_q [2**(AW+1)];

    assign vs_rise = vs & ~vs_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        drop_d    = drop_q;
        fv_d      = fv_q;
        done_d    = 1'b0;
        we        = 1'b0;
        waddr     = '0;
        fill      = (state_q == StFill);
        cur_col   = col_q;
        cur_row   = row_q;

        // Frame boundary is resolved first so a coincident sample lands in the new frame.
        if (vs_rise) begin
            if (state_q == StFull) begin
                wr_bank_d = ~wr_bank_q;
                rd_bank_d = ~rd_bank_q;
                done_d    = 1'b1;
                fv_d      = 1'b1;
            end else if (col_q != '0 || row_q != '0) begin
                drop_d = 1'b1;
            end
            fill    = 1'b1;
            cur_col = '0;
            cur_row = '0;
            state_d = StFill;
            col_d   = '0;
            row_d   = '0;
        end

        if (data_vaild) begin
            if (fill) begin
                we    = 1'b1;
                waddr = AW'(cur_row) * AW'(BLK_X) + AW'(cur_col);
                if (cur_col == CW'(BLK_X - 1)) begin
                    col_d = '0;
                    if (cur_row == RW'(BLK_Y - 1)) begin
                        row_d   = '0;
                        state_d = StFull;
                    end else begin
                        row_d = cur_row + 1'b1;
                    end
                end else begin
                    col_d = cur_col + 1'b1;
                    row_d = cur_row;
                end
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[{wr_bank_d, waddr}] <= block_mean;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StFill;
            col_q      <= '0;
            row_q      <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            vs_q       <= 1'b0;
            drop_q     <= 1'b0;
            fv_q       <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            vs_q       <= vs;
            drop_q     <= drop_d;
            fv_q       <= fv_d;
            done_q     <= done_d;
            rd_valid_q <= rd_en;
            // Uses the pre-swap bank and published flag when a swap coincides.
            if (rd_en) begin
                if (fv_q && (32'(rd_addr) < Depth)) begin
                    rd_data_q <= mem_q[{rd_bank_q, rd_addr}];
                end else begin
                    rd_data_q <= '0;
                end
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign frame_done  = done_q;
    assign frame_valid = fv_q;
    assign drop_err    = drop_q;

endmodule
